mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single data-memory port (4 KiB block RAM plus IO map at `addr[10]=1`) between the instruction-fetch stage and the load/store stage. It sits between the pipeline stages and the memory read/write stage. It drives that stage's `bank_en`, `re`, `addr` and `w_data`, and returns read data with a uniform one-cycle latency for both RAM and IO addresses. Data-port priority is fixed, with a starvation guard for fetch.

---
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between fetch and load/store.
// Data wins by default; a saturating counter lets a starved fetch through.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int IO_BIT     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [3:0]  m_bank_en,
  output logic        m_re,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  logic [3:0]  r_starve;
  logic        r_rsp_valid;
  logic        r_rsp_owner;
  logic        r_rsp_io;
  logic [31:0] r_io_hold;

  logic        w_fetch_pri;
  logic        w_d_rd;
  logic        w_rd_gnt;
  logic [31:0] w_rdata;

  assign w_fetch_pri = (r_starve == 4'(STARVE_MAX));
  assign w_d_rd      = (d_we == 4'h0);

  assign i_gnt = ~rst & i_req & (~d_req | w_fetch_pri);
  assign d_gnt = ~rst & d_req & ~i_gnt;

  assign w_rd_gnt = i_gnt | (d_gnt & w_d_rd);

  // Steer the granted requester onto the memory port; idle port is all zero.
  always_comb begin
    m_bank_en = 4'h0;
    m_re      = 1'b0;
    m_addr    = 32'h0;
    m_wdata   = 32'h0;
    unique case (1'b1)
      i_gnt: begin
        m_addr = i_addr;
        m_re   = 1'b1;
      end
      d_gnt: begin
        m_addr    = d_addr;
        m_re      = w_d_rd;
        m_bank_en = d_we;
        m_wdata   = w_d_rd ? 32'h0 : d_wdata;
      end
      default: ;
    endcase
  end

  // Count consecutive blocked fetch cycles, saturating at the threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= 4'h0;
    end else if (i_gnt) begin
      r_starve <= 4'h0;
    end else if (i_req && !w_fetch_pri) begin
      r_starve <= r_starve + 4'h1;
    end
  end

  // Remember who owns the read in flight and latch IO data at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= 1'b0;
      r_rsp_io    <= 1'b0;
      r_io_hold   <= 32'h0;
    end else begin
      r_rsp_valid <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rsp_owner <= d_gnt;
        r_rsp_io    <= m_addr[IO_BIT];
        r_io_hold   <= m_rdata;
      end
    end
  end

  assign w_rdata  = r_rsp_io ? r_io_hold : m_rdata;
  assign i_rdata  = w_rdata;
  assign d_rdata  = w_rdata;
  assign i_rvalid = ~rst & r_rsp_valid & ~r_rsp_owner;
  assign d_rvalid = ~rst & r_rsp_valid & r_rsp_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus, memory-stage stand-in and
// a rule-level reference model checked on every falling edge.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [3:0]  m_bank_en;
  logic        m_re;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(.STARVE_MAX(SMAX), .IO_BIT(10)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_bank_en(m_bank_en), .m_re(m_re), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory-stage stand-in: registered RAM read, combinational IO read.
  logic [31:0] mem_ram [1024];
  logic [31:0] mem_io  [16];
  logic [31:0] ram_q;

  always @(posedge clk) begin
    if (m_re) ram_q <= mem_ram[m_addr[11:2]];
    for (int b = 0; b < 4; b++) begin
      if (m_bank_en[b]) begin
        if (m_addr[10]) mem_io[m_addr[5:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        else mem_ram[m_addr[11:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
    end
  end

  assign m_rdata = (m_re && m_addr[10]) ? mem_io[m_addr[5:2]] : ram_q;

  // Reference model state: its own copy of memory contents and counters.
  logic [31:0] ram_m [1024];
  logic [31:0] io_m  [16];
  int          mstarve = 0;
  bit          er_i = 0;
  bit          er_d = 0;
  logic [31:0] exp_rd = 32'h0;

  initial begin
    for (int k = 0; k < 1024; k++) begin
      mem_ram[k] = 32'hC000_0000 | 32'(k);
      ram_m[k]   = 32'hC000_0000 | 32'(k);
    end
    for (int k = 0; k < 16; k++) begin
      mem_io[k] = 32'h0;
      io_m[k]   = 32'h0;
    end
    mem_ram[4] = 32'hDEAD_BEEF;
    ram_m[4]   = 32'hDEAD_BEEF;
    ram_q      = 32'h0;
  end

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return a[10] ? io_m[a[5:2]] : ram_m[a[11:2]];
  endfunction

  // Compare process: check DUT against the model, then advance the model.
  always @(negedge clk) begin
    bit          wi, wd;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        er;
    if (rst) begin
      er_i = 0;
      er_d = 0;
    end
    chk("i_rvalid", 32'(i_rvalid), 32'(er_i));
    chk("d_rvalid", 32'(d_rvalid), 32'(er_d));
    if (er_i) chk("i_rdata", i_rdata, exp_rd);
    if (er_d) chk("d_rdata", d_rdata, exp_rd);

    wi = !rst && i_req && (!d_req || mstarve == SMAX);
    wd = !rst && d_req && !wi;
    chk("i_gnt", 32'(i_gnt), 32'(wi));
    chk("d_gnt", 32'(d_gnt), 32'(wd));

    ea = 32'h0; ew = 32'h0; eb = 4'h0; er = 1'b0;
    if (wi) begin
      ea = i_addr; er = 1'b1;
    end else if (wd) begin
      ea = d_addr;
      er = (d_we == 4'h0);
      eb = d_we;
      ew = (d_we == 4'h0) ? 32'h0 : d_wdata;
    end
    chk("m_addr", m_addr, ea);
    chk("m_re", 32'(m_re), 32'(er));
    chk("m_bank_en", 32'(m_bank_en), 32'(eb));
    chk("m_wdata", m_wdata, ew);

    er_i = wi;
    er_d = wd && (d_we == 4'h0);
    if (er_i || er_d) exp_rd = mrd(ea);
    if (wd && d_we != 4'h0) begin
      for (int b = 0; b < 4; b++) begin
        if (d_we[b]) begin
          if (d_addr[10]) io_m[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
          else ram_m[d_addr[11:2]][8*b +: 8] = d_wdata[8*b +: 8];
        end
      end
    end
    if (rst || wi) mstarve = 0;
    else if (i_req && mstarve < SMAX) mstarve = mstarve + 1;
  end

  logic [3:0] g_bank;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_i(input logic [31:0] a);
    bit got = 0;
    i_req  = 1'b1;
    i_addr = a;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_gnt) begin
        got = 1;
        break;
      end
      step();
    end
    chk("i_gnt_wait", 32'(got), 32'd1);
    step();
    i_req = 1'b0;
  endtask

  task automatic req_d(input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] wd);
    bit got = 0;
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_gnt) begin
        got = 1;
        g_bank = m_bank_en;
        break;
      end
      step();
    end
    chk("d_gnt_wait", 32'(got), 32'd1);
    step();
    d_req = 1'b0;
    d_we  = 4'h0;
  endtask

  logic [14:0] pat;

  initial begin
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h30; d_wdata = 32'h0;
    g_bank = 4'h0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", {30'h0, i_gnt, d_gnt}, 32'h0);
      chk("rst_m_re", 32'(m_re), 32'h0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_d_gnt", 32'(d_gnt), 32'd1);
    chk("post_rst_i_gnt", 32'(i_gnt), 32'd0);
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk("held_fetch_gnt", 32'(i_gnt), 32'd1);
    step();
    i_req = 1'b0;
    step();

    req_i(32'h10);
    @(negedge clk);
    chk("fetch_rvalid", 32'(i_rvalid), 32'd1);
    chk("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("fetch_no_drv", 32'(d_rvalid), 32'd0);
    step();

    req_d(4'hF, 32'h20, 32'h1234_5678);
    chk("wr_bank_en", 32'(g_bank), 32'hF);
    req_d(4'h0, 32'h20, 32'h0);
    @(negedge clk);
    chk("rd_back", d_rdata, 32'h1234_5678);
    step();

    req_d(4'h3, 32'h24, 32'hFFFF_ABCD);
    chk("part_bank_en", 32'(g_bank), 32'h3);
    req_d(4'h0, 32'h24, 32'h0);
    @(negedge clk);
    chk("part_rd", d_rdata, 32'hC000_ABCD);
    step();

    req_d(4'hF, 32'h400, 32'hA5A5_A5A5);
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h400;
    i_req = 1'b1; i_addr = 32'h0;
    @(negedge clk);
    chk("io_d_gnt", 32'(d_gnt), 32'd1);
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk("io_rvalid", 32'(d_rvalid), 32'd1);
    chk("io_rdata", d_rdata, 32'hA5A5_A5A5);
    chk("io_next_fetch", 32'(i_gnt), 32'd1);
    step();
    i_req = 1'b0;
    @(negedge clk);
    chk("io_fetch_rdata", i_rdata, 32'hC000_0000);
    step();

    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h20;
    i_req = 1'b1; i_addr = 32'h10;
    pat = 15'h0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      pat = {pat[13:0], i_gnt};
      step();
    end
    d_req = 1'b0;
    i_req = 1'b0;
    chk("starve_pattern", 32'(pat), 32'(15'b000010000100001));
    step();

    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    chk("pre_rst_gnt", 32'(i_gnt), 32'd1);
    step();
    i_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_t1", 32'(i_rvalid), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_drop_t2", 32'(i_rvalid), 32'd0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
